// File: rtl/pong_match_pkg.sv
// Shared types and constants for the pong match controller.
// Optional BCD score outputs are enabled by the PONG_MATCH_BCD_EN macro.
package pong_match_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_OVER
  } state_e;

  localparam int M_SCORE_W = 4;
  localparam int RND_NUM_W = 9;

  localparam int LFSR_W = 9;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 9'h1FF;

  // x^9 + x^5 + 1 -> feedback from stages 9 and 5
  localparam int TAP_HI = 8;
  localparam int TAP_LO = 4;

`ifdef PONG_MATCH_BCD_EN
  function automatic logic [7:0] to_bcd(input logic [7:0] v);
    logic [7:0] tens;
    logic [7:0] ones;
    tens = v / 8'd10;
    ones = v % 8'd10;
    return {tens[3:0], ones[3:0]};
  endfunction
`endif

endpackage

// File: rtl/pong_match_if.sv
// Match controller bus: key/frame/point inputs and
// game state, score, random and BCD outputs.
interface pong_match_if #(
  parameter int M_SCORE_W = 4,
  parameter int RND_NUM_W = 9
);

  logic                 game_rst_i;
  logic                 new_frame_i;
  logic                 p_point_i;
  logic                 e_point_i;
  logic                 game_en_o;
  logic [M_SCORE_W-1:0] player_score_o;
  logic [M_SCORE_W-1:0] enemy_score_o;
  logic                 winner_o;
  logic [RND_NUM_W-1:0] rnd_num_o;
  logic [7:0]           player_bcd_o;
  logic [7:0]           enemy_bcd_o;

  modport master (
    output game_rst_i,
    output new_frame_i,
    output p_point_i,
    output e_point_i,
    input  game_en_o,
    input  player_score_o,
    input  enemy_score_o,
    input  winner_o,
    input  rnd_num_o,
    input  player_bcd_o,
    input  enemy_bcd_o
  );

  modport slave (
    input  game_rst_i,
    input  new_frame_i,
    input  p_point_i,
    input  e_point_i,
    output game_en_o,
    output player_score_o,
    output enemy_score_o,
    output winner_o,
    output rnd_num_o,
    output player_bcd_o,
    output enemy_bcd_o
  );

endinterface

// File: rtl/pong_match_lfsr.sv
// Free-running 9-bit Fibonacci LFSR, x^9 + x^5 + 1.
// Never reaches the all-zero state from the non-zero seed.
module match_lfsr #(
  parameter int RND_NUM_W = pong_match_pkg::RND_NUM_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic [RND_NUM_W-1:0] rnd_num_o
);

  import pong_match_pkg::*;

  logic [LFSR_W-1:0] lfsr_q;
  logic              fb;

  assign fb = lfsr_q[TAP_HI] ^ lfsr_q[TAP_LO];

  // shift every cycle, feedback enters at bit 0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[LFSR_W-2:0], fb};
    end
  end

  assign rnd_num_o = RND_NUM_W'(lfsr_q);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match controller: IDLE/PLAY/OVER FSM, saturating scores,
// winner flag, LFSR and optional BCD outputs (PONG_MATCH_BCD_EN).
module pong_match_ctrl #(
  parameter int WIN_SCORE = 5,
  parameter int M_SCORE_W = pong_match_pkg::M_SCORE_W,
  parameter int RND_NUM_W = pong_match_pkg::RND_NUM_W
) (
  input logic        clk_i,
  input logic        rst_i,
  pong_match_if.slave bus
);

  import pong_match_pkg::*;

  localparam logic [M_SCORE_W-1:0] WIN = M_SCORE_W'(WIN_SCORE);

  state_e               state_q;
  state_e               state_d;
  logic                 game_rst_q;
  logic                 start;
  logic                 enter_play;
  logic                 game_en;
  logic [M_SCORE_W-1:0] ps_q;
  logic [M_SCORE_W-1:0] es_q;
  logic                 winner_q;

  assign start = bus.game_rst_i & ~game_rst_q;
  assign enter_play = (state_d == ST_PLAY) &&
                      (state_q != ST_PLAY);

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and Moore play-enable
  always_comb begin
    state_d = state_q;
    game_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        game_en = 1'b1;
        if (ps_q == WIN || es_q == WIN)
          state_d = ST_OVER;
      end
      ST_OVER: begin
        if (start) state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // key edge register, scores and winner flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      game_rst_q <= 1'b0;
      ps_q       <= '0;
      es_q       <= '0;
      winner_q   <= 1'b0;
    end else begin
      game_rst_q <= bus.game_rst_i;
      if (enter_play) begin
        ps_q <= '0;
        es_q <= '0;
      end else if (state_q == ST_PLAY &&
                   bus.new_frame_i) begin
        if (bus.p_point_i && ps_q != WIN)
          ps_q <= ps_q + 1'b1;
        if (bus.e_point_i && es_q != WIN)
          es_q <= es_q + 1'b1;
      end
      if (state_q == ST_PLAY &&
          state_d == ST_OVER)
        winner_q <= (ps_q == WIN);
    end
  end

  match_lfsr #(
    .RND_NUM_W(RND_NUM_W)
  ) u_lfsr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rnd_num_o(bus.rnd_num_o)
  );

  assign bus.game_en_o      = game_en;
  assign bus.player_score_o = ps_q;
  assign bus.enemy_score_o  = es_q;
  assign bus.winner_o       = winner_q;

`ifdef PONG_MATCH_BCD_EN
  assign bus.player_bcd_o = to_bcd(8'(ps_q));
  assign bus.enemy_bcd_o  = to_bcd(8'(es_q));
`else
  assign bus.player_bcd_o = 8'h00;
  assign bus.enemy_bcd_o  = 8'h00;
`endif

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Testbench for pong_match_ctrl: directed matches plus random
// play checked against a behavioural match model.
module tb_pong_match_ctrl;

  localparam int W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pong_match_if #(
    .M_SCORE_W(4),
    .RND_NUM_W(9)
  ) bus ();

  pong_match_ctrl #(
    .WIN_SCORE(W),
    .M_SCORE_W(4),
    .RND_NUM_W(9)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model: mode 0 = waiting, 1 = playing, 2 = finished
  int m_mode;
  int m_ps;
  int m_es;
  int m_win;
  int m_prev;
  int m_lfsr;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic int exp_bcd(input int s);
`ifdef PONG_MATCH_BCD_EN
    return ((s / 10) << 4) | (s % 10);
`else
    return (s >= 0) ? 0 : 0;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_ps   = 0;
    m_es   = 0;
    m_win  = 0;
    m_prev = 0;
    m_lfsr = 'h1FF;
  endtask

  task automatic model_step(input int g, input int f,
                            input int p, input int e);
    int start;
    start = (g == 1 && m_prev == 0) ? 1 : 0;
    case (m_mode)
      0: if (start == 1) begin
        m_mode = 1; m_ps = 0; m_es = 0;
      end
      1: begin
        if (m_ps == W || m_es == W) begin
          m_mode = 2;
          m_win = (m_ps == W) ? 1 : 0;
        end
        if (f == 1) begin
          if (p == 1 && m_ps < W) m_ps++;
          if (e == 1 && m_es < W) m_es++;
        end
      end
      default: if (start == 1) begin
        m_mode = 1; m_ps = 0; m_es = 0;
      end
    endcase
    m_prev = g;
    m_lfsr = ((m_lfsr << 1) & 'h1FF) |
             (((m_lfsr >> 8) ^ (m_lfsr >> 4)) & 1);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".en"}, 32'(bus.game_en_o),
          (m_mode == 1) ? 1 : 0);
    check({tag, ".ps"}, 32'(bus.player_score_o), m_ps);
    check({tag, ".es"}, 32'(bus.enemy_score_o), m_es);
    check({tag, ".win"}, 32'(bus.winner_o), m_win);
    check({tag, ".rnd"}, 32'(bus.rnd_num_o), m_lfsr);
    check({tag, ".pbcd"}, 32'(bus.player_bcd_o),
          exp_bcd(m_ps));
    check({tag, ".ebcd"}, 32'(bus.enemy_bcd_o),
          exp_bcd(m_es));
  endtask

  // drive away from the edge, advance model, sample #1 after
  task automatic step(input string tag, input logic g,
                      input logic f, input logic p,
                      input logic e);
    bus.game_rst_i  = g;
    bus.new_frame_i = f;
    bus.p_point_i   = p;
    bus.e_point_i   = e;
    model_step(int'(g), int'(f), int'(p), int'(e));
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    bus.game_rst_i  = 1'b0;
    bus.new_frame_i = 1'b0;
    bus.p_point_i   = 1'b0;
    bus.e_point_i   = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic g;
    bit   seen [512];
    int   v;
    int   bad;

    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 20; i++)
      step("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_rnd_nz",
          32'(bus.rnd_num_o != 9'h000), 1);

    step("start", 1'b1, 1'b0, 1'b0, 1'b0);
    step("start_lo", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("p3", 1'b0, 1'b1, 1'b1, 1'b0);
    check("p3_en", 32'(bus.game_en_o), 1);
    check("p3_ps", 32'(bus.player_score_o), 3);
`ifdef PONG_MATCH_BCD_EN
    check("p3_bcd", 32'(bus.player_bcd_o), 'h03);
`else
    check("p3_bcd", 32'(bus.player_bcd_o), 'h00);
`endif

    for (int i = 0; i < 2; i++)
      step("p5", 1'b0, 1'b1, 1'b1, 1'b0);
    step("to_over", 1'b0, 1'b1, 1'b1, 1'b0);
    check("over_en", 32'(bus.game_en_o), 0);
    check("over_win", 32'(bus.winner_o), 1);
    for (int i = 0; i < 3; i++)
      step("over_pts", 1'b0, 1'b1, 1'b1, 1'b1);
    check("over_ps_sat", 32'(bus.player_score_o), W);

    step("restart", 1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_en", 32'(bus.game_en_o), 1);
    check("restart_ps", 32'(bus.player_score_o), 0);
    for (int i = 0; i < W + 1; i++)
      step("held", 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      step("held_over", 1'b1, 1'b0, 1'b0, 1'b0);
    check("held_no_restart", 32'(bus.game_en_o), 0);

    step("rel", 1'b0, 1'b0, 1'b0, 1'b0);
    step("tie_start", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step("tie44", 1'b0, 1'b1, 1'b1, 1'b1);
    step("tie55", 1'b0, 1'b1, 1'b1, 1'b1);
    check("tie_es", 32'(bus.enemy_score_o), W);
    step("tie_over", 1'b0, 1'b0, 1'b0, 1'b0);
    check("tie_en", 32'(bus.game_en_o), 0);
    check("tie_winner", 32'(bus.winner_o), 1);

    g = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) g = ~g;
      step("rand", g,
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 2) == 0));
    end

    step("ar_lo", 1'b0, 1'b0, 1'b0, 1'b0);
    step("ar_hi", 1'b1, 1'b0, 1'b0, 1'b0);
    step("ar_st", 1'b0, 1'b0, 1'b0, 1'b0);
    step("ar_st2", 1'b1, 1'b0, 1'b0, 1'b0);
    step("ar_pt", 1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_en", 32'(bus.game_en_o), 0);
    check("async_ps", 32'(bus.player_score_o), 0);
    check("async_es", 32'(bus.enemy_score_o), 0);
    check("async_rnd", 32'(bus.rnd_num_o), 'h1FF);

    @(posedge clk);
    #1;
    do_reset();
    bad = 0;
    foreach (seen[k]) seen[k] = 1'b0;
    seen[9'h1FF] = 1'b1;
    for (int i = 1; i <= 511; i++) begin
      step("lfsr", 1'b0, 1'b0, 1'b0, 1'b0);
      v = int'(bus.rnd_num_o);
      if (i < 511) begin
        if (v == 0 || seen[v]) bad++;
        seen[v] = 1'b1;
      end
    end
    check("lfsr_repeat", bad, 0);
    check("lfsr_period", 32'(bus.rnd_num_o), 'h1FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 5, is the score at which a match ends (1..9).
REQ-002 Parameter M_SCORE_W, default 4, is the score counter width.
REQ-003 Parameter RND_NUM_W, default 9, is the random-number width.
REQ-004 Port clk_i, input, 1 bit: the single clock; one clock, all logic on posedge.
REQ-005 Port rst_i, input, 1 bit: reset is asynchronous and active-high.
REQ-006 Port game_rst_i, input, 1 bit: start/restart key, active-high level.
REQ-007 Port new_frame_i, input, 1 bit: one-cycle frame strobe.
REQ-008 Port p_point_i, input, 1 bit: player scored; sampled only with new_frame_i.
REQ-009 Port e_point_i, input, 1 bit: enemy scored; sampled only with new_frame_i.
REQ-010 Port game_en_o, output, 1 bit: play active.
REQ-011 Port player_score_o, output, M_SCORE_W bits: player score.
REQ-012 Port enemy_score_o, output, M_SCORE_W bits: enemy score.
REQ-013 Port winner_o, output, 1 bit: 1 = player won last match, 0 = enemy won; valid in OVER.
REQ-014 Port rnd_num_o, output, RND_NUM_W bits: free-running pseudo-random value.
REQ-015 Port player_bcd_o, output, 8 bits: player score as {tens, ones} BCD.
REQ-016 Port enemy_bcd_o, output, 8 bits: enemy score as {tens, ones} BCD.

Function
REQ-017 The FSM SHALL have states IDLE, PLAY and OVER; game_en_o SHALL be 1 only in PLAY (Moore output).
REQ-018 A start event SHALL be the rising edge of game_rst_i (registered previous value, one-cycle pulse).
REQ-019 IDLE -> PLAY on a start event; OVER -> PLAY on a start event; a start event in PLAY SHALL be ignored.
REQ-020 On every transition into PLAY, both scores SHALL be cleared in the same cycle the state changes.
REQ-021 In PLAY, on new_frame_i=1, player_score_o SHALL increment by 1 if p_point_i=1 and enemy_score_o SHALL increment by 1 if e_point_i=1; simultaneous points SHALL increment both.
REQ-022 Scores SHALL saturate at WIN_SCORE and SHALL not change outside PLAY.
REQ-023 PLAY -> OVER in the cycle after either registered score equals WIN_SCORE.
REQ-024 On that transition, winner_o SHALL be set to 1 if the player score equals WIN_SCORE, and 0 otherwise; if both scores equal WIN_SCORE, the player wins.
REQ-025 The LFSR SHALL be a 9-bit Fibonacci LFSR with polynomial x^9+x^5+1, shifting every clock regardless of state; seed 9'h1FF; the all-zero state SHALL never be reached.
REQ-026 BCD outputs SHALL be combinational from the score registers: tens = score/10, ones = score%10.

Reset
REQ-027 During rst_i: state=IDLE, game_en_o=0, scores=0, winner_o=0, LFSR=9'h1FF, edge-detect register=0.
REQ-028 Reset asserted mid-match SHALL abort to IDLE immediately and asynchronously.

Configuration
REQ-029 With macro PONG_MATCH_BCD_EN defined, player_bcd_o/enemy_bcd_o SHALL carry BCD scores; without it, both SHALL be tied to 0 and the converters SHALL not be synthesised.

Structure
REQ-030 Package pong_match_pkg SHALL hold the state enum, M_SCORE_W, RND_NUM_W, the LFSR seed and the tap positions.
REQ-031 The LFSR SHALL be the sub-module match_lfsr (ports clk_i, rst_i, rnd_num_o); the FSM and scoring SHALL stay in the top module.

Verification
REQ-032 Reset, then hold game_rst_i=0 for 20 cycles -> game_en_o=0, scores=0, rnd_num_o is not 0.
REQ-033 Pulse game_rst_i, then give 3 frames with p_point_i=1 -> game_en_o=1, player_score_o=3, player_bcd_o=8'h03.
REQ-034 Give 5 player points (WIN_SCORE=5) -> OVER, game_en_o=0, winner_o=1; further points leave the score at 5.
REQ-035 In OVER, pulse game_rst_i -> PLAY next cycle with both scores 0; holding game_rst_i high gives no second restart.
REQ-036 In PLAY, give one frame with p_point_i=e_point_i=1 from 4:4 -> 5:5, then OVER with winner_o=1.
REQ-037 Run the LFSR for 511 cycles after reset -> the value returns to 9'h1FF, with no zero state and no earlier repeat.
